// File: rtl/ifu_fq.sv
// ifu_fq : instruction fetch unit with a decoupling fetch queue.
//
// Keeps up to MAX_OUTSTANDING instruction reads in flight on a split
// request/response memory bus. Returned words are stored with their PCs in an
// FQ_DEPTH-entry FIFO and presented to the decode stage under valid/ready.
// A flush redirects fetch, empties the queue, and silently discards responses
// to any request issued before the flush.
//
// Ports:
//   clk, rstn                       core clock, asynchronous active-low reset
//   rst_pc                          fetch address loaded while rstn is low
//   ac2if_flush, ac2if_flush_pc     one-cycle redirect and its target
//   imem_req_valid/ready/addr       fetch request channel (addr held while stalled)
//   imem_resp_valid/data            in-order read data, always accepted
//   if_valid/ready                  queue head handshake toward the idu
//   if_pc, if_pc_plus, if_inst      head PC, head PC + 4, head instruction
//   if_fq_count                     current queue occupancy
module ifu_fq #(
    parameter int FQ_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W          = $clog2(FQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      rst_pc,
    input  logic             ac2if_flush,
    input  logic [31:0]      ac2if_flush_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus,
    output logic [31:0]      if_inst,
    output logic [CNT_W-1:0] if_fq_count
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FQ_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_pc_q   [FQ_DEPTH];
    logic [31:0]      fifo_pc_d   [FQ_DEPTH];
    logic [31:0]      fifo_inst_q [FQ_DEPTH];
    logic [31:0]      fifo_inst_d [FQ_DEPTH];

    logic [CNT_W:0]   in_use;
    logic             req_fire;
    logic             push;
    logic             pop;

    // A request is only issued when a queue slot is already reserved for its
    // response (in flight + queued < depth), so pushes can never overflow.
    // Credit from a same-cycle pop is deliberately not used. The rstn term
    // keeps the request quiet while reset is held.
    assign in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = rstn && !ac2if_flush
                            && (outstanding_q < MAX_OUT_C) && (in_use < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are pushed only once every pre-flush read has drained.
    assign push = imem_resp_valid && (drop_cnt_q == '0);

    assign if_valid    = (count_q != '0) && !ac2if_flush;
    assign pop         = if_valid && if_ready;
    assign if_pc       = fifo_pc_q[rd_ptr_q];
    assign if_pc_plus  = if_pc + 32'd4;
    assign if_inst     = fifo_inst_q[rd_ptr_q];
    assign if_fq_count = count_q;

    // Flush overrides every other update: the queue empties, both PCs jump to
    // the target, and whatever is still in flight (minus a response landing
    // this cycle, which is itself discarded) becomes the drop budget.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        for (int i = 0; i < FQ_DEPTH; i++) begin
            fifo_pc_d[i]   = fifo_pc_q[i];
            fifo_inst_d[i] = fifo_inst_q[i];
        end

        if (ac2if_flush) begin
            fetch_pc_d    = ac2if_flush_pc;
            resp_pc_d     = ac2if_flush_pc;
            outstanding_d = outstanding_q - CNT_W'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - CNT_W'(imem_resp_valid);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = resp_pc_q;
                fifo_inst_d[wr_ptr_q] = imem_resp_data;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; the queue storage is cleared on reset so the head
    // outputs are defined (zero) before the first fill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q    <= rst_pc;
            resp_pc_q     <= rst_pc;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fifo_pc_q[i]   <= fifo_pc_d[i];
                fifo_inst_q[i] <= fifo_inst_d[i];
            end
        end
    end

    // Protocol and bookkeeping invariants.
    resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rstn)
        imem_resp_valid |-> (outstanding_q != '0));
    drop_within_outstanding: assert property (@(posedge clk) disable iff (!rstn)
        (drop_cnt_q <= outstanding_q) && (outstanding_q <= MAX_OUT_C));
    credit_within_depth: assert property (@(posedge clk) disable iff (!rstn)
        in_use <= DEPTH_C);

endmodule

// File: tb/tb_ifu_fq.sv
// tb_ifu_fq : self-checking bench for ifu_fq.
//
// A behavioural memory returns reads in order after a per-request latency.
// The reference model works at the architectural level: the address stream and
// the delivered PC stream are each sequential from the last reset/redirect,
// every response belongs to an "epoch" that a flush retires, and the queue
// occupancy is simply live responses minus accepted instructions.
module tb_ifu_fq;

    localparam int FQ_DEPTH = 4;
    localparam int MAX_OUT  = 2;
    localparam int CNT_W    = $clog2(FQ_DEPTH + 1);

    logic             clk;
    logic             rstn;
    logic [31:0]      rst_pc;
    logic             ac2if_flush;
    logic [31:0]      ac2if_flush_pc;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [31:0]      imem_req_addr;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_data;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_pc;
    logic [31:0]      if_pc_plus;
    logic [31:0]      if_inst;
    logic [CNT_W-1:0] if_fq_count;

    ifu_fq #(.FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn), .rst_pc(rst_pc),
        .ac2if_flush(ac2if_flush), .ac2if_flush_pc(ac2if_flush_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_pc_plus(if_pc_plus), .if_inst(if_inst), .if_fq_count(if_fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          model_cnt = 0;
    int          stale_drops = 0;
    int          req_total = 0;
    int          pop_total = 0;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_if_pc;
    logic [31:0] last_pop_pc;

    logic        flush_drv = 1'b0;
    logic [31:0] flush_pc_drv = 32'h0;
    logic        if_ready_drv = 1'b0;
    int          if_ready_pct = -1;
    int          req_ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive at the falling edge, check 1ns later, then update
    // the model at the rising edge from what was driven and observed.
    task automatic step();
        logic        fl;
        logic [31:0] fpc;
        logic        resp_now;
        logic        hs_req;
        logic        hs_pop;
        logic        exp_req_v;
        logic        exp_if_v;
        req_t        r;
        @(negedge clk);
        fl  = flush_drv;
        fpc = flush_pc_drv;
        ac2if_flush    = fl;
        ac2if_flush_pc = fpc;
        if_ready       = (if_ready_pct < 0) ? if_ready_drv
                                            : (int'($urandom_range(99)) < if_ready_pct);
        imem_req_ready = (int'($urandom_range(99)) < req_ready_pct);
        resp_now = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(memq[0].addr) : $urandom();
        #1;
        exp_if_v  = (model_cnt != 0) && !fl;
        exp_req_v = !fl && (memq.size() < MAX_OUT) && (memq.size() + model_cnt < FQ_DEPTH);
        checks++;
        if (if_fq_count !== CNT_W'(model_cnt)) begin
            errors++;
            $display("[TB] FAIL fq_count cyc %0d: got %0d expected %0d", cyc, if_fq_count, model_cnt);
        end
        checks++;
        if (if_valid !== exp_if_v) begin
            errors++;
            $display("[TB] FAIL if_valid cyc %0d: got %b expected %b", cyc, if_valid, exp_if_v);
        end
        checks++;
        if (imem_req_valid !== exp_req_v) begin
            errors++;
            $display("[TB] FAIL req_valid cyc %0d: got %b expected %b", cyc, imem_req_valid, exp_req_v);
        end
        checks++;
        if (imem_req_addr !== exp_req_addr) begin
            errors++;
            $display("[TB] FAIL req_addr cyc %0d: got %h expected %h", cyc, imem_req_addr, exp_req_addr);
        end
        hs_req = imem_req_valid && imem_req_ready;
        hs_pop = if_valid && if_ready;
        if (hs_pop) begin
            checks++;
            if (if_pc !== exp_if_pc) begin
                errors++;
                $display("[TB] FAIL if_pc cyc %0d: got %h expected %h", cyc, if_pc, exp_if_pc);
            end
            checks++;
            if (if_inst !== mem_word(exp_if_pc)) begin
                errors++;
                $display("[TB] FAIL if_inst cyc %0d: got %h expected %h", cyc, if_inst, mem_word(exp_if_pc));
            end
            checks++;
            if (if_pc_plus !== exp_if_pc + 32'd4) begin
                errors++;
                $display("[TB] FAIL if_pc_plus cyc %0d: got %h expected %h", cyc, if_pc_plus, exp_if_pc + 32'd4);
            end
            last_pop_pc = if_pc;
        end
        @(posedge clk);
        if (resp_now) begin
            r = memq.pop_front();
            if (fl || r.epoch != epoch) stale_drops++;
            else model_cnt++;
        end
        if (fl) begin
            model_cnt    = 0;
            epoch++;
            exp_req_addr = fpc;
            exp_if_pc    = fpc;
        end else begin
            if (hs_pop) begin
                model_cnt--;
                exp_if_pc = exp_if_pc + 32'd4;
                pop_total++;
            end
            if (hs_req) begin
                r.addr  = imem_req_addr;
                r.epoch = epoch;
                r.due   = cyc + int'($urandom_range(lat_max, lat_min));
                memq.push_back(r);
                exp_req_addr = exp_req_addr + 32'd4;
                req_total++;
            end
        end
        cyc++;
    endtask

    // Assert reset (memory model included); leaves rstn low.
    task automatic do_reset(input logic [31:0] pc);
        rst_pc          = pc;
        rstn            = 1'b0;
        ac2if_flush     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        if_ready        = 1'b0;
        flush_drv       = 1'b0;
        memq.delete();
        model_cnt    = 0;
        epoch++;
        exp_req_addr = pc;
        exp_if_pc    = pc;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(32'h8000_0000);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valids: got req %b if %b expected 0 0", imem_req_valid, if_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h expected 80000000", imem_req_addr);
        end
        checks++;
        if (if_fq_count !== '0 || if_inst !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_queue: got count %0d inst %h expected 0 0", if_fq_count, if_inst);
        end
        checks++;
        if (if_pc_plus !== if_pc + 32'd4) begin
            errors++;
            $display("[TB] FAIL reset_pc_plus: got %h expected %h", if_pc_plus, if_pc + 32'd4);
        end
        release_reset();
    endtask

    task automatic test_stream();
        int p0;
        lat_min = 1; lat_max = 1; req_ready_pct = 100; if_ready_drv = 1'b1;
        repeat (4) step();
        p0 = pop_total;
        repeat (20) step();
        checks++;
        if (pop_total - p0 != 20) begin
            errors++;
            $display("[TB] FAIL stream_gapless: got %0d pops expected 20", pop_total - p0);
        end
    endtask

    task automatic test_backpressure();
        int h0;
        do_reset(32'h8000_0000);
        release_reset();
        lat_min = 1; lat_max = 1; if_ready_drv = 1'b0;
        h0 = req_total;
        repeat (12) step();
        #1;
        checks++;
        if (req_total - h0 != FQ_DEPTH) begin
            errors++;
            $display("[TB] FAIL bp_requests: got %0d expected %0d", req_total - h0, FQ_DEPTH);
        end
        checks++;
        if (if_fq_count !== CNT_W'(FQ_DEPTH) || imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full: got count %0d req %b expected %0d 0", if_fq_count, imem_req_valid, FQ_DEPTH);
        end
        if_ready_drv = 1'b1;
        step();
        if_ready_drv = 1'b0;
        h0 = req_total;
        repeat (6) step();
        checks++;
        if (req_total - h0 != 1) begin
            errors++;
            $display("[TB] FAIL bp_one_credit: got %0d requests expected 1", req_total - h0);
        end
    endtask

    task automatic test_slow_mem();
        int   max_out = 0;
        logic saw_block = 1'b0;
        lat_min = 3; lat_max = 3; if_ready_drv = 1'b1;
        repeat (30) begin
            step();
            #1;
            if (memq.size() > max_out) max_out = memq.size();
            if (memq.size() == MAX_OUT && !imem_req_valid) saw_block = 1'b1;
        end
        checks++;
        if (max_out > MAX_OUT) begin
            errors++;
            $display("[TB] FAIL slow_max_outstanding: got %0d expected <= %0d", max_out, MAX_OUT);
        end
        checks++;
        if (saw_block !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slow_req_blocked: got %b expected 1", saw_block);
        end
    endtask

    task automatic test_flush();
        int   s0;
        int   p0;
        logic found = 1'b0;
        do_reset(32'h8000_0000);
        release_reset();
        lat_min = 3; lat_max = 3; if_ready_drv = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (memq.size() == 2 && model_cnt == 2 && memq[0].due > cyc) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL flush_setup: got no 2+2 state expected one within 40 cycles");
        end
        s0 = stale_drops;
        flush_drv = 1'b1; flush_pc_drv = 32'h0000_1000;
        step();
        flush_drv = 1'b0;
        #1;
        checks++;
        if (if_fq_count !== '0 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_empty: got count %0d valid %b expected 0 0", if_fq_count, if_valid);
        end
        if_ready_drv = 1'b1;
        p0 = pop_total;
        for (int i = 0; i < 30 && pop_total == p0; i++) step();
        checks++;
        if (pop_total == p0 || last_pop_pc !== 32'h0000_1000) begin
            errors++;
            $display("[TB] FAIL flush_first_pc: got %h (pops %0d) expected 00001000", last_pop_pc, pop_total - p0);
        end
        checks++;
        if (stale_drops - s0 != 2) begin
            errors++;
            $display("[TB] FAIL flush_dropped: got %0d expected 2", stale_drops - s0);
        end
    endtask

    task automatic test_back_to_back_flush();
        int   p0;
        logic found = 1'b0;
        lat_min = 1; lat_max = 1; if_ready_drv = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 10 && !found; i++) begin
            if (memq.size() != 0 && memq[0].due <= cyc) found = 1'b1;
            else step();
        end
        flush_drv = 1'b1; flush_pc_drv = 32'h0000_2000;
        step();
        flush_pc_drv = 32'h0000_3000;
        step();
        flush_drv = 1'b0;
        p0 = pop_total;
        for (int i = 0; i < 30 && pop_total == p0; i++) step();
        checks++;
        if (pop_total == p0 || last_pop_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL b2b_first_pc: got %h (pops %0d) expected 00003000", last_pop_pc, pop_total - p0);
        end
        p0 = pop_total;
        repeat (10) step();
        checks++;
        if (pop_total - p0 != 10) begin
            errors++;
            $display("[TB] FAIL b2b_resume: got %0d pops expected 10", pop_total - p0);
        end
    endtask

    task automatic test_stall_and_reset();
        logic [31:0] a0;
        int          h0;
        lat_min = 1; lat_max = 1; if_ready_drv = 1'b1;
        repeat (3) step();
        #1;
        a0 = imem_req_addr;
        h0 = req_total;
        req_ready_pct = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            checks++;
            if (imem_req_addr !== a0) begin
                errors++;
                $display("[TB] FAIL stall_addr %0d: got %h expected %h", i, imem_req_addr, a0);
            end
        end
        checks++;
        if (req_total != h0 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d handshakes valid %b expected 0 1", req_total - h0, imem_req_valid);
        end
        req_ready_pct = 100;
        repeat (6) step();
        #2;
        rst_pc = 32'h4000_0000;
        rstn   = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_fq_count !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got req %b if %b count %0d expected 0 0 0",
                     imem_req_valid, if_valid, if_fq_count);
        end
        checks++;
        if (imem_req_addr !== 32'h4000_0000 || if_inst !== 32'h0 || if_pc_plus !== if_pc + 32'd4) begin
            errors++;
            $display("[TB] FAIL midreset_values: got addr %h inst %h pc_plus %h expected 40000000 0 %h",
                     imem_req_addr, if_inst, if_pc_plus, if_pc + 32'd4);
        end
        do_reset(32'h4000_0000);
        release_reset();
        if_ready_drv = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_random();
        int p0;
        p0 = pop_total;
        lat_min = 1; lat_max = 4; req_ready_pct = 75; if_ready_pct = 70;
        for (int i = 0; i < 400; i++) begin
            flush_drv    = ($urandom_range(24) == 0);
            flush_pc_drv = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        flush_drv = 1'b0;
        if_ready_pct = -1;
        checks++;
        if (pop_total - p0 < 20) begin
            errors++;
            $display("[TB] FAIL random_progress: got %0d pops expected >= 20", pop_total - p0);
        end
    endtask

    initial begin
        rstn            = 1'b0;
        rst_pc          = 32'h8000_0000;
        ac2if_flush     = 1'b0;
        ac2if_flush_pc  = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if_ready        = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_slow_mem();
        test_flush();
        test_back_to_back_flush();
        test_stall_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
